// File: rtl/alu_pkg.sv
// Shared encodings for the shift-then-ALU pipeline: ALU ops, shift modes and
// NZCV flag bit positions.
package alu_pkg;

  typedef enum logic [2:0] {
    ALU_ADD   = 3'b000,
    ALU_SUB   = 3'b001,
    ALU_AND   = 3'b010,
    ALU_OR    = 3'b011,
    ALU_XOR   = 3'b100,
    ALU_PASS  = 3'b101,
    ALU_ZERO0 = 3'b110,
    ALU_ZERO1 = 3'b111
  } alu_op_e;

  typedef enum logic [1:0] {
    SH_LSL = 2'b00,
    SH_LSR = 2'b01,
    SH_ASR = 2'b10,
    SH_ROR = 2'b11
  } shift_mode_e;

  localparam int FLAG_N = 3;
  localparam int FLAG_Z = 2;
  localparam int FLAG_C = 1;
  localparam int FLAG_V = 0;

endpackage

// File: rtl/shift_unit.sv
// Combinational barrel shifter applied to operand a ahead of the ALU.
// Over-range amounts (non-power-of-2 WIDTH) flush LSL/LSR to 0 and ASR to sign.
module shift_unit
  import alu_pkg::*;
#(
  parameter  int WIDTH = 8,
  localparam int SHW   = $clog2(WIDTH)
) (
  input  logic [WIDTH-1:0] a,
  input  logic [SHW-1:0]   shamt,
  input  shift_mode_e      mode,
  output logic [WIDTH-1:0] y
);

  logic [SHW-1:0]     rot;
  logic [2*WIDTH-1:0] dbl;

  // Rotation wraps modulo WIDTH; a doubled copy turns it into a plain shift.
  assign rot = SHW'(int'(shamt) % WIDTH);
  assign dbl = {a, a} >> rot;

  always_comb begin
    y = a;
    case (mode)
      SH_LSL:  y = a << shamt;
      SH_LSR:  y = a >> shamt;
      SH_ASR:  y = $signed(a) >>> shamt;
      SH_ROR:  y = dbl[WIDTH-1:0];
      default: y = a;
    endcase
  end

endmodule

// File: rtl/alu_shift_pipe.sv
// Two-stage shift-then-ALU pipeline with valid/ready backpressure and a sticky
// NZCV register loaded on the output handshake of flag-writing ops.
module alu_shift_pipe
  import alu_pkg::*;
#(
  parameter  int WIDTH = 8,
  localparam int SHW   = $clog2(WIDTH)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic [2:0]       alu_control,
  input  logic [SHW-1:0]   shamt,
  input  logic [1:0]       shift_mode,
  input  logic             flags_we,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] result,
  output logic [3:0]       alu_flags,
  output logic [3:0]       nzcv
);

  // Handshake: a transfer happens on a rising edge where valid and ready are
  // both high; a producer holds valid and payload steady until that edge, and
  // ready may depend combinationally on the downstream ready (no skid buffer).

  logic             s1_valid;
  logic [WIDTH-1:0] s1_sa;
  logic [WIDTH-1:0] s1_b;
  alu_op_e          s1_op;
  logic             s1_we;

  logic             s2_valid;
  logic             s2_we;

  logic             s1_adv;
  logic             s2_adv;
  logic [WIDTH-1:0] sa;

  logic [WIDTH-1:0] b_op;
  logic             cin;
  logic [WIDTH:0]   sum;
  logic [WIDTH-1:0] alu_res;
  logic             c_flag;
  logic             v_flag;
  logic [3:0]       flags;

  assign s2_adv    = ~s2_valid | out_ready;
  assign s1_adv    = ~s1_valid | s2_adv;
  assign in_ready  = s1_adv & ~reset;
  assign out_valid = s2_valid;

  shift_unit #(.WIDTH(WIDTH)) u_shift (
    .a     (a),
    .shamt (shamt),
    .mode  (shift_mode_e'(shift_mode)),
    .y     (sa)
  );

  always_comb begin
    b_op    = s1_b;
    cin     = 1'b0;
    alu_res = '0;
    c_flag  = 1'b0;
    v_flag  = 1'b0;
    // Subtraction reuses the adder as sa + ~b + 1, so C=1 means no borrow.
    if (s1_op == ALU_SUB) begin
      b_op = ~s1_b;
      cin  = 1'b1;
    end
    sum = {1'b0, s1_sa} + {1'b0, b_op} + {{WIDTH{1'b0}}, cin};
    case (s1_op)
      ALU_ADD, ALU_SUB: begin
        alu_res = sum[WIDTH-1:0];
        c_flag  = sum[WIDTH];
        v_flag  = (s1_sa[WIDTH-1] == b_op[WIDTH-1]) &&
                  (alu_res[WIDTH-1] != s1_sa[WIDTH-1]);
      end
      ALU_AND:  alu_res = s1_sa & s1_b;
      ALU_OR:   alu_res = s1_sa | s1_b;
      ALU_XOR:  alu_res = s1_sa ^ s1_b;
      ALU_PASS: alu_res = s1_sa;
      default:  alu_res = '0;
    endcase
    flags         = 4'b0000;
    flags[FLAG_N] = alu_res[WIDTH-1];
    flags[FLAG_Z] = (alu_res == '0);
    flags[FLAG_C] = c_flag;
    flags[FLAG_V] = v_flag;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      s1_valid  <= 1'b0;
      s1_sa     <= '0;
      s1_b      <= '0;
      s1_op     <= ALU_ADD;
      s1_we     <= 1'b0;
      s2_valid  <= 1'b0;
      s2_we     <= 1'b0;
      result    <= '0;
      alu_flags <= 4'b0000;
      nzcv      <= 4'b0000;
    end else begin
      if (s1_adv) begin
        s1_valid <= in_valid;
        if (in_valid) begin
          s1_sa <= sa;
          s1_b  <= b;
          s1_op <= alu_op_e'(alu_control);
          s1_we <= flags_we;
        end
      end
      if (s2_adv) begin
        s2_valid <= s1_valid;
        if (s1_valid) begin
          result    <= alu_res;
          alu_flags <= flags;
          s2_we     <= s1_we;
        end
      end
      if (s2_valid && out_ready && s2_we) begin
        nzcv <= alu_flags;
      end
    end
  end

endmodule

// File: tb/tb_alu_shift_pipe.sv
// Directed bench for alu_shift_pipe (WIDTH=8): a driver pushes hand-computed
// {result, flags} into exp_q on accept; a monitor pops on each output handshake.
module tb_alu_shift_pipe;

  localparam int WIDTH = 8;
  localparam int SHW   = $clog2(WIDTH);
  localparam int EW    = WIDTH + 4;

  typedef struct {
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic [2:0]       op;
    logic [SHW-1:0]   sh;
    logic [1:0]       mode;
    logic [WIDTH-1:0] res;
    logic [3:0]       fl;
  } vec_t;

  logic             clk;
  logic             reset;
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic [2:0]       alu_control;
  logic [SHW-1:0]   shamt;
  logic [1:0]       shift_mode;
  logic             flags_we;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] result;
  logic [3:0]       alu_flags;
  logic [3:0]       nzcv;

  logic [EW-1:0] exp_q[$];
  vec_t          vq[$];
  int            checks;
  int            errors;
  int            n_out;
  int            cyc;

  alu_shift_pipe #(.WIDTH(WIDTH)) dut (
    .clk         (clk),
    .reset       (reset),
    .in_valid    (in_valid),
    .in_ready    (in_ready),
    .a           (a),
    .b           (b),
    .alu_control (alu_control),
    .shamt       (shamt),
    .shift_mode  (shift_mode),
    .flags_we    (flags_we),
    .out_valid   (out_valid),
    .out_ready   (out_ready),
    .result      (result),
    .alu_flags   (alu_flags),
    .nzcv        (nzcv)
  );

  // ---------------- clock / reset ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  initial begin
    #200000;
    $display("FAIL watchdog time limit reached");
    $fatal(1, "watchdog");
  end

  // ---------------- checking helpers ----------------
  task automatic check(input string name, input logic [31:0] got, input logic [31:0] req);
    checks++;
    if (got !== req) begin
      errors++;
      $display("FAIL %s got=0x%0h required=0x%0h", name, got, req);
    end
  endtask

  // ---------------- monitor / scoreboard ----------------
  initial begin
    forever begin
      @(negedge clk);
      if (!reset && out_valid && out_ready) begin
        n_out++;
        checks++;
        if (exp_q.size() == 0) begin
          errors++;
          $display("FAIL unexpected_output got=0x%0h flags=%b", result, alu_flags);
        end else begin
          logic [EW-1:0] e;
          e = exp_q.pop_front();
          if ({result, alu_flags} !== e) begin
            errors++;
            $display("FAIL output got res=0x%0h fl=%b required res=0x%0h fl=%b",
                     result, alu_flags, e[EW-1:4], e[3:0]);
          end
        end
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic drive(input vec_t v, input logic we);
    a           = v.a;
    b           = v.b;
    alu_control = v.op;
    shamt       = v.sh;
    shift_mode  = v.mode;
    flags_we    = we;
    in_valid    = 1'b1;
  endtask

  task automatic send(input vec_t v, input logic we);
    bit ok;
    logic acc;
    ok = 0;
    drive(v, we);
    for (int i = 0; i < 50; i++) begin
      @(negedge clk);
      acc = in_ready;
      @(posedge clk);
      if (acc) begin
        exp_q.push_back({v.res, v.fl});
        ok = 1;
        break;
      end
    end
    #1 in_valid = 1'b0;
    if (!ok) begin
      checks++;
      errors++;
      $display("FAIL send_timeout a=0x%0h op=%b", v.a, v.op);
    end
  endtask

  task automatic try_send(input vec_t v, output logic acc);
    drive(v, 1'b0);
    @(negedge clk);
    acc = in_ready;
    @(posedge clk);
    if (acc) exp_q.push_back({v.res, v.fl});
    #1 in_valid = 1'b0;
  endtask

  task automatic drain(input string name);
    int i;
    for (i = 0; i < 100 && exp_q.size() != 0; i++) @(posedge clk);
    #1;
    check(name, exp_q.size(), 0);
  endtask

  task automatic add_vec(input logic [7:0] va, input logic [7:0] vb, input logic [2:0] op,
                         input logic [2:0] sh, input logic [1:0] md,
                         input logic [7:0] res, input logic [3:0] fl);
    vec_t v;
    v.a = va; v.b = vb; v.op = op; v.sh = sh; v.mode = md; v.res = res; v.fl = fl;
    vq.push_back(v);
  endtask

  // ---------------- stimulus ----------------
  initial begin
    logic acc;
    int   n_acc;
    int   c0;
    int   n0;
    logic [15:0] rpat;

    checks = 0; errors = 0; n_out = 0; cyc = 0;
    reset = 1'b1; in_valid = 1'b0; out_ready = 1'b1;
    a = '0; b = '0; alu_control = '0; shamt = '0; shift_mode = '0; flags_we = 1'b0;

    //        a      b      op      sh    mode   res    {N,Z,C,V}
    add_vec(8'h7F, 8'h01, 3'b000, 3'd0, 2'b00, 8'h80, 4'b1001); // 0 add overflow
    add_vec(8'h05, 8'h05, 3'b001, 3'd0, 2'b00, 8'h00, 4'b0110); // 1 sub equal
    add_vec(8'h90, 8'h00, 3'b101, 3'd2, 2'b10, 8'hE4, 4'b1000); // 2 ASR
    add_vec(8'h81, 8'h00, 3'b101, 3'd1, 2'b11, 8'hC0, 4'b1000); // 3 ROR
    add_vec(8'h81, 8'h00, 3'b101, 3'd7, 2'b01, 8'h01, 4'b0000); // 4 LSR
    add_vec(8'h81, 8'hFF, 3'b000, 3'd1, 2'b00, 8'h01, 4'b0010); // 5 LSL then add
    add_vec(8'hF0, 8'h3C, 3'b010, 3'd0, 2'b00, 8'h30, 4'b0000); // 6 and
    add_vec(8'h0F, 8'hA0, 3'b011, 3'd0, 2'b00, 8'hAF, 4'b1000); // 7 or
    add_vec(8'hAA, 8'hAA, 3'b100, 3'd0, 2'b00, 8'h00, 4'b0100); // 8 xor zero
    add_vec(8'hFF, 8'h12, 3'b111, 3'd0, 2'b00, 8'h00, 4'b0100); // 9 op 111
    add_vec(8'h00, 8'h01, 3'b001, 3'd0, 2'b00, 8'hFF, 4'b1000); // 10 sub borrow
    add_vec(8'h80, 8'h01, 3'b001, 3'd0, 2'b00, 8'h7F, 4'b0011); // 11 sub overflow
    add_vec(8'h5A, 8'h00, 3'b101, 3'd0, 2'b11, 8'h5A, 4'b0000); // 12 ROR by 0
    add_vec(8'h81, 8'h00, 3'b101, 3'd4, 2'b11, 8'h18, 4'b0000); // 13 ROR by 4
    add_vec(8'h33, 8'h44, 3'b110, 3'd0, 2'b00, 8'h00, 4'b0100); // 14 op 110

    // Reset state
    #12;
    check("rst_in_ready", in_ready, 0);
    check("rst_out_valid", out_valid, 0);
    check("rst_result", result, 0);
    check("rst_alu_flags", alu_flags, 0);
    check("rst_nzcv", nzcv, 0);
    @(posedge clk); #1 reset = 1'b0;
    @(posedge clk); #1;
    check("post_rst_in_ready", in_ready, 1);

    // Latency: out_valid rises on the second edge after the request is driven
    send(vq[0], 1'b1);
    check("lat_not_early", out_valid, 0);
    @(posedge clk); #1;
    check("lat_out_valid", out_valid, 1);
    @(posedge clk); #1;
    check("nzcv_add_ovf", nzcv, 4'b1001);

    // Full-rate stream with out_ready high
    c0 = cyc;
    for (int i = 1; i < vq.size(); i++) send(vq[i], 1'b0);
    check("throughput_cycles", cyc - c0, vq.size() - 1);
    drain("drain_stream");
    check("nzcv_hold_we0", nzcv, 4'b1001);

    // flags_we gating
    send(vq[8], 1'b0);
    drain("drain_we0");
    check("nzcv_zero_we0", nzcv, 4'b1001);
    send(vq[8], 1'b1);
    @(posedge clk); #1;
    check("nzcv_before_hs", nzcv, 4'b1001);
    @(posedge clk); #1;
    check("nzcv_after_hs", nzcv, 4'b0100);
    drain("drain_we1");

    // Backpressure: two entries held, third refused, stable outputs
    out_ready = 1'b0;
    n0 = n_out;
    n_acc = 0;
    for (int i = 2; i < 5; i++) begin
      try_send(vq[i], acc);
      if (acc) n_acc++;
    end
    check("bp_accepted", n_acc, 2);
    check("bp_in_ready", in_ready, 0);
    check("bp_out_valid", out_valid, 1);
    check("bp_result", result, 8'hE4);
    repeat (3) @(posedge clk);
    #1;
    check("bp_result_stable", result, 8'hE4);
    check("bp_flags_stable", alu_flags, 4'b1000);
    check("bp_valid_stable", out_valid, 1);
    out_ready = 1'b1;
    drain("drain_bp");
    check("bp_out_count", n_out - n0, 2);
    send(vq[4], 1'b0);
    drain("drain_bp_retry");

    // Stream under a fixed out_ready pattern
    rpat = 16'b1011_0010_1110_0101;
    fork
      begin
        for (int i = 0; i < vq.size(); i++) send(vq[i], 1'b0);
      end
      begin
        for (int k = 0; k < 40; k++) begin
          @(posedge clk);
          #1 out_ready = rpat[k % 16];
        end
        out_ready = 1'b1;
      end
    join
    out_ready = 1'b1;
    drain("drain_pattern");

    // Reset with both stages full
    send(vq[1], 1'b1);
    drain("drain_pre_rst");
    check("pre_rst_nzcv", nzcv, 4'b0110);
    out_ready = 1'b0;
    send(vq[0], 1'b1);
    send(vq[11], 1'b1);
    @(posedge clk);
    #2 reset = 1'b1;
    #1;
    check("mid_rst_out_valid", out_valid, 0);
    check("mid_rst_nzcv", nzcv, 0);
    check("mid_rst_in_ready", in_ready, 0);
    exp_q.delete();
    n0 = n_out;
    @(posedge clk); #1 reset = 1'b0;
    out_ready = 1'b1;
    repeat (6) @(posedge clk);
    #1;
    check("post_rst_no_stale", n_out - n0, 0);
    check("post_rst_out_valid", out_valid, 0);
    check("post_rst_nzcv", nzcv, 0);

    // Pipeline works again after reset
    send(vq[5], 1'b0);
    drain("drain_final");

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
